// File: rtl/freq_sel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : freq_sel_pkg                                                 |
// | Description : Shared constants and FSM encoding for the bin-selection path |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package freq_sel_pkg;

    localparam int unsigned c_DATA_W    = 32;
    localparam int unsigned c_IDX_W     = 14;
    localparam int unsigned c_SLOT_W    = 7;
    localparam int unsigned c_RING_LAT  = 2;
    localparam int unsigned c_LAT_CNT_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_SYNC    = 2'd0;
    localparam state_t c_ST_RUN     = 2'd1;
    localparam state_t c_ST_WAIT    = 2'd2;
    localparam state_t c_ST_REALIGN = 2'd3;

endpackage
`default_nettype wire

// File: rtl/freq_sel_stream_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : freq_sel_stream_if                                           |
// | Description : AXI-Stream style bundle (data, user, valid, last, ready)     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface freq_sel_stream_if
    import freq_sel_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int USER_W = c_IDX_W
) ();

    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tuser, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tuser, input tvalid, input tlast, output tready);

endinterface
`default_nettype wire

// File: rtl/axis_out_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_out_reg                                                 |
// | Description : One-deep AXI-Stream holding register                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axis_out_reg
    import freq_sel_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int USER_W = c_SLOT_W
) (
    input  wire logic              dev_clk,
    input  wire logic              dev_rstn,
    input  wire logic              i_load,
    input  wire logic [DATA_W-1:0] i_data,
    input  wire logic [USER_W-1:0] i_user,
    input  wire logic              i_last,
    output logic                   o_ready,
    freq_sel_stream_if.master      m_axis
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [USER_W-1:0] r_user;
    logic              r_last;

    // The producer only loads when o_ready is high, so a load never overwrites
    // a beat the consumer has not taken.
    assign o_ready       = ~r_valid | m_axis.tready;
    assign m_axis.tvalid = r_valid;
    assign m_axis.tdata  = r_data;
    assign m_axis.tuser  = r_user;
    assign m_axis.tlast  = r_last;

    always_ff @(posedge dev_clk or negedge dev_rstn) begin
        if (!dev_rstn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_user  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_user  <= i_user;
            r_last  <= i_last;
        end else if (m_axis.tready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/freq_sel_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : freq_sel_stream                                              |
// | Description : Picks ring-listed bins out of a channelizer frame stream     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module freq_sel_stream
    import freq_sel_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W,
    parameter int IDX_W    = c_IDX_W,
    parameter int SLOT_W   = c_SLOT_W,
    parameter int RING_LAT = c_RING_LAT
) (
    input  wire logic             dev_clk,
    input  wire logic             dev_rstn,
    input  wire logic             enable,
    freq_sel_stream_if.slave      s_axis,
    input  wire logic [IDX_W-1:0] sel_index,
    input  wire logic [SLOT_W-1:0] sel_count,
    input  wire logic             ring_ready,
    output logic                  rd_en_ring,
    freq_sel_stream_if.master     m_axis,
    output logic [31:0]           frame_cnt,
    output logic [15:0]           miss_cnt
);

    localparam logic [c_LAT_CNT_W-1:0] c_LAT_INIT = c_LAT_CNT_W'(RING_LAT - 1);

    state_t                 r_state;
    logic                   r_alive;
    logic [SLOT_W-1:0]      r_k;
    logic                   r_en_f;
    logic [SLOT_W-1:0]      r_adv;
    logic [SLOT_W-1:0]      r_pulse_cnt;
    logic [c_LAT_CNT_W-1:0] r_lat_cnt;
    logic                   r_rd_en;
    logic [31:0]            r_frame_cnt;
    logic [15:0]            r_miss_cnt;

    logic              w_out_ready;
    logic              w_s_tready;
    logic              w_acc;
    logic              w_run_acc;
    logic              w_match;
    logic [SLOT_W-1:0] w_adv_next;
    logic              w_frame_done;
    logic              w_en_next;

    // r_alive keeps s_tready low while reset is held and for the first cycle after.
    assign w_s_tready   = r_alive & ((r_state == c_ST_SYNC) |
                                     ((r_state == c_ST_RUN) & w_out_ready));
    assign w_acc        = s_axis.tvalid & w_s_tready;
    assign w_run_acc    = w_acc & (r_state == c_ST_RUN);
    assign w_match      = w_run_acc & r_en_f & (r_adv < r_k) & (s_axis.tuser == sel_index);
    assign w_adv_next   = w_match ? r_adv + SLOT_W'(1) : r_adv;
    assign w_frame_done = (w_adv_next == r_k) | ~r_en_f;
    assign w_en_next    = enable & ring_ready & (sel_count != '0);

    assign s_axis.tready = w_s_tready;
    assign rd_en_ring    = r_rd_en;
    assign frame_cnt     = r_frame_cnt;
    assign miss_cnt      = r_miss_cnt;

    axis_out_reg #(
        .DATA_W (DATA_W),
        .USER_W (SLOT_W)
    ) u_out_reg (
        .dev_clk  (dev_clk),
        .dev_rstn (dev_rstn),
        .i_load   (w_match),
        .i_data   (s_axis.tdata),
        .i_user   (r_adv),
        .i_last   (r_adv == (r_k - SLOT_W'(1))),
        .o_ready  (w_out_ready),
        .m_axis   (m_axis)
    );

    always_ff @(posedge dev_clk or negedge dev_rstn) begin
        if (!dev_rstn) begin
            r_state     <= c_ST_SYNC;
            r_alive     <= 1'b0;
            r_k         <= '0;
            r_en_f      <= 1'b0;
            r_adv       <= '0;
            r_pulse_cnt <= '0;
            r_lat_cnt   <= '0;
            r_rd_en     <= 1'b0;
            r_frame_cnt <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_alive <= 1'b1;
            r_rd_en <= 1'b0;
            case (r_state)
                c_ST_SYNC: begin
                    if (w_acc && s_axis.tlast) begin
                        r_state <= c_ST_RUN;
                        r_k     <= sel_count;
                        r_en_f  <= w_en_next;
                        r_adv   <= '0;
                    end
                end
                c_ST_RUN: begin
                    if (w_match) begin
                        r_rd_en   <= 1'b1;
                        r_adv     <= w_adv_next;
                        r_lat_cnt <= c_LAT_INIT;
                        r_state   <= c_ST_WAIT;
                    end
                    // Frame end is evaluated after this beat's match has been counted.
                    if (w_run_acc && s_axis.tlast) begin
                        if (w_frame_done) begin
                            r_frame_cnt <= r_frame_cnt + 32'd1;
                            r_k         <= sel_count;
                            r_en_f      <= w_en_next;
                            r_adv       <= '0;
                        end else begin
                            r_pulse_cnt <= r_k - w_adv_next;
                            r_state     <= c_ST_REALIGN;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (r_lat_cnt == '0) begin
                        r_state <= c_ST_RUN;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                c_ST_REALIGN: begin
                    if (r_pulse_cnt != '0) begin
                        r_rd_en     <= 1'b1;
                        r_pulse_cnt <= r_pulse_cnt - SLOT_W'(1);
                        r_lat_cnt   <= c_LAT_INIT;
                    end else if (r_lat_cnt != '0) begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end else begin
                        r_frame_cnt <= r_frame_cnt + 32'd1;
                        if (r_miss_cnt != 16'hFFFF) begin
                            r_miss_cnt <= r_miss_cnt + 16'd1;
                        end
                        r_k     <= sel_count;
                        r_en_f  <= w_en_next;
                        r_adv   <= '0;
                        r_state <= c_ST_RUN;
                    end
                end
                default: r_state <= c_ST_SYNC;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/freq_sel_stream.md
FREQ_SEL_STREAM -- requirements
Module: freq_sel_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning channel sample width (16-bit I + 16-bit Q).
REQ-002 SHALL have parameter IDX_W, default 14, meaning bin-index width, matching the ring entry width.
REQ-003 SHALL have parameter SLOT_W, default 7, meaning ring slot-number width (up to 128 entries).
REQ-004 SHALL have parameter RING_LAT, default 2, meaning cycles from a rd_en_ring pulse to a valid sel_index.
REQ-005 SHALL have the following ports (name, direction, width, meaning):
- dev_clk, in, 1: the only clock.
- dev_rstn, in, 1: reset, asynchronous assert, active-low.
- enable, in, 1: selection enable.
- s_tdata, in, DATA_W: channelizer sample.
- s_tuser, in, IDX_W: bin index of the sample.
- s_tvalid, in, 1: input handshake valid.
- s_tlast, in, 1: last bin of the frame.
- s_tready, out, 1: input handshake ready.
- sel_index, in, IDX_W: current ring head (ring dout_mon).
- sel_count, in, SLOT_W: number of ring entries.
- ring_ready, in, 1: ring populated and valid.
- rd_en_ring, out, 1: advance the ring head by one.
- m_tdata, out, DATA_W: selected sample.
- m_tuser, out, SLOT_W: slot number of the selected sample.
- m_tvalid, out, 1: output handshake valid.
- m_tlast, out, 1: last slot of the frame.
- m_tready, in, 1: output handshake ready.
- frame_cnt, out, 32: completed frames.
- miss_cnt, out, 16: frames that needed realignment.

Function
REQ-006 SHALL implement the FSM SYNC, RUN, WAIT, REALIGN; the reset state is SYNC.
REQ-007 In SYNC, s_tready SHALL be 1 and all beats SHALL be discarded; on an accepted beat with s_tlast=1 the FSM SHALL go to RUN, latching K=sel_count and en_f=enable&ring_ready&(K!=0).
REQ-008 In RUN, a beat SHALL be accepted when s_tvalid & s_tready; s_tready SHALL be 1 only if the output register is empty or m_tready=1.
REQ-009 On an accepted beat with en_f=1, adv<K and s_tuser==sel_index, the block SHALL:
- load the output register with m_tdata=s_tdata, m_tuser=adv, m_tlast=(adv==K-1);
- pulse rd_en_ring for one cycle;
- increment adv;
- go to WAIT.
REQ-010 WAIT SHALL hold s_tready=0 for exactly RING_LAT cycles, then return to RUN; a matching beat is therefore followed by at least RING_LAT stall cycles.
REQ-011 On an accepted beat with s_tlast=1 (after any match on the same beat is processed), the block SHALL handle the frame end as follows:
- if adv==K or en_f=0: increment frame_cnt, re-latch K and en_f, clear adv, and continue in RUN (via WAIT if this beat matched);
- otherwise: go to REALIGN.
REQ-012 REALIGN SHALL do the following:
- issue K-adv back-to-back single-cycle rd_en_ring pulses with s_tready=0;
- then wait RING_LAT cycles;
- increment frame_cnt and miss_cnt (saturating), re-latch K and en_f, clear adv;
- return to RUN.
REQ-013 Non-matching beats SHALL be accepted and dropped without any rd_en_ring pulse.
REQ-014 Duplicate consecutive ring entries SHALL produce one output per frame; the unmatched remainder SHALL be recovered by REALIGN.
REQ-015 Changes to enable or sel_count SHALL take effect only at the next frame boundary.
REQ-016 m_tvalid SHALL stay asserted with stable m_tdata, m_tuser and m_tlast until m_tready=1 (AXI-Stream rules).
REQ-017 frame_cnt SHALL wrap modulo 2^32; miss_cnt SHALL saturate at 0xFFFF.

Reset
REQ-018 While dev_rstn=0, all of the following SHALL be 0: s_tready, rd_en_ring, m_tvalid, m_tdata, m_tuser, m_tlast, frame_cnt, miss_cnt, adv, K, en_f.
REQ-019 The FSM SHALL be in SYNC during reset, and state reached after reset mid-frame SHALL remain SYNC until the next s_tlast.

Structure
REQ-020 The shared package freq_sel_pkg SHALL hold the FSM state encoding and the default IDX_W, SLOT_W and RING_LAT constants.
REQ-021 The output register SHALL be a sub-module named axis_out_reg (a one-deep AXI-Stream holding register).

Verification
REQ-022 Verification SHALL cover the following directed scenarios:
- K=3, ring {5,9,12}, frames of 16 bins 0..15, m_tready=1 -> outputs bins 5,9,12 with m_tuser 0,1,2; m_tlast on bin 12; 3 rd_en pulses per frame; miss_cnt=0.
- Ring {5,9,40}, 16-bin frame -> 2 outputs, then REALIGN issues 1 pulse; miss_cnt=1; next frame outputs bins 5 and 9 again.
- enable=0 for a frame -> no outputs and no rd_en; frame_cnt still increments.
- Scenario 1 with m_tready held 0 for 10 cycles after bin 5 -> s_tready=0 throughout; no beat lost; bin 9 is output after release.
- dev_rstn pulsed low mid-frame -> all outputs 0; FSM in SYNC; the first output appears only in the frame after the next s_tlast.
- RING_LAT=2: s_tready is low for exactly 2 cycles after each rd_en pulse.
